// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and field widths.
package imem_loader_defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int BIDX_W = 2;
  localparam int LEN_W  = 16;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_busy(input state_t s);
    return s inside {LEN_LO, LEN_HI, DATA, CHK};
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog for the loader: counts enabled cycles without a clear.
// TIMEOUT = 0 disables expiry entirely.
module loader_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear || !enable)
      cnt <= '0;
    else if (cnt != LAST)
      cnt <= cnt + CW'(1);
  end

  // Expires on the TIMEOUT-th consecutive cycle with no accepted byte.
  assign expired = (TIMEOUT != 0) && enable && !clear && (cnt == LAST);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory while holding the core.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_defs::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t            state, state_next;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  word_cnt;
  logic [BIDX_W-1:0] byte_idx;
  logic [23:0]       asm_q;
  logic              we_q;
  logic              accept;
  logic              last_byte;
  logic              last_word;
  logic              tmo_expired;
  logic [LEN_W-1:0]  n_rx;

  assign byte_ready = is_busy(state);
  assign accept     = byte_valid && byte_ready;
  assign n_rx       = {byte_data, len_lo};
  assign last_byte  = (byte_idx == BIDX_W'(3));
  assign last_word  = (word_cnt == len - LEN_W'(1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
`endif

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (byte_ready),
    .clear   (accept),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (load_start) state_next = LEN_LO;
      LEN_LO:          if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if ({16'd0, n_rx} > 32'(DEPTH)) state_next = ERR;
          else if (n_rx == '0)            state_next = END_STATE;
          else                            state_next = DATA;
        end
      end
      DATA:            if (accept && last_byte && last_word) state_next = END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:             if (accept) state_next = (byte_data == chk_q) ? DONE : ERR;
`endif
      default:         state_next = IDLE;
    endcase
    if (tmo_expired) state_next = ERR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (!byte_ready && load_start) begin
        word_cnt <= '0;
        byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_q    <= '0;
`endif
      end
      if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state != CHK) chk_q <= chk_q ^ byte_data;
`endif
        case (state)
          LEN_LO: len_lo <= byte_data;
          LEN_HI: begin
            len      <= n_rx;
            word_cnt <= '0;
            byte_idx <= '0;
          end
          DATA: begin
            // Little-endian: earlier bytes slide toward bit 0.
            asm_q    <= {byte_data, asm_q[23:8]};
            byte_idx <= byte_idx + BIDX_W'(1);
            if (last_byte) begin
              we_q       <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= {byte_data, asm_q};
              word_cnt   <= word_cnt + LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Reset masks the write strobe and hold line in the same cycle it is asserted.
  assign imem_we    = we_q && !reset;
  assign core_hold  = (is_busy(state) || state == ERR) && !reset;
  assign load_done  = (state == DONE);
  assign load_error = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized images against a queue-based reference.
// Define IMEM_LOADER_CHECKSUM_EN for both DUT and bench to exercise the checksum stage.
module tb_imem_loader;

  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1024;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_error;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stalls = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [31:0]       words[64];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // All driving happens just after a falling edge.
  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    w = 0;
    while (byte_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w != 0) stalls++;
    if (byte_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL byte_accept_timeout: byte_ready=%b after %0d cycles, required 1", byte_ready, w);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Sends length, words and (if enabled) checksum. chk_byte < 0 means send the correct XOR.
  task automatic send_image(input int n, input int gmin, input int gmax,
                            input int chk_byte, input bit glitch);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    b = n[7:0];  x ^= b; send_byte(b, $urandom_range(gmax, gmin));
    b = n[15:8]; x ^= b; send_byte(b, $urandom_range(gmax, gmin));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        x ^= b;
        send_byte(b, $urandom_range(gmax, gmin));
      end
      if (glitch && i == 0) pulse_start();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte((chk_byte < 0) ? x : chk_byte[7:0], $urandom_range(gmax, gmin));
`endif
  endtask

  task automatic check_writes(input string name, input int n);
    total++;
    if (wr_addr_q.size() !== n) begin
      bad++;
      $display("FAIL %s_count: writes=%0d, required %0d", name, wr_addr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== words[i]) begin
          bad++;
          $display("FAIL %s_word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                   name, i, wr_addr_q[i], wr_data_q[i], i, words[i]);
        end
      end
    end
    clear_writes();
  endtask

  task automatic check_flags(input string name, input logic done, input logic err,
                             input logic hold);
    total++;
    if ({load_done, load_error, core_hold} !== {done, err, hold}) begin
      bad++;
      $display("FAIL %s_flags: done/err/hold=%b%b%b, required %b%b%b",
               name, load_done, load_error, core_hold, done, err, hold);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({byte_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_error} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
               byte_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_error);
    end
    reset = 1'b0;
    @(negedge clk);
    clear_writes();
  endtask

  task automatic test_basic();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_006F;
    pulse_start();
    check_flags("basic_busy", 1'b0, 1'b0, 1'b1);
    send_image(2, 0, 0, -1, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("basic", 2);
    check_flags("basic_end", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    stalls = 0;
    pulse_start();
    send_image(2, 1, 1, -1, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("gaps", 2);
    check_flags("gaps_end", 1'b1, 1'b0, 1'b0);
    total++;
    if (stalls !== 0) begin
      bad++;
      $display("FAIL gaps_ready: stalled bytes=%0d, required 0", stalls);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      stalls = 0;
      pulse_start();
      send_image(n, 0, (it % 2 == 0) ? 0 : 3, -1, (n > 1));
      repeat (2) @(negedge clk);
      check_writes($sformatf("random%0d", it), n);
      check_flags($sformatf("random%0d_end", it), 1'b1, 1'b0, 1'b0);
      total++;
      if (stalls !== 0) begin
        bad++;
        $display("FAIL random%0d_ready: stalled bytes=%0d, required 0", it, stalls);
      end
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_image(0, 0, 0, -1, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("zero", 0);
    check_flags("zero_end", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_oversize();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check_flags("oversize", 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check_writes("oversize", 0);
    total++;
    if (byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL oversize_ready: byte_ready=%b, required 0", byte_ready);
    end
  endtask

  task automatic test_depth_boundary();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    repeat (2) @(negedge clk);
    check_flags("depth_ok", 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_flags("depth_idle", 1'b0, 1'b1, 1'b1);
    check_writes("depth", 0);
  endtask

  task automatic test_timeout();
    words[0] = $urandom;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(words[0][7:0], 0);
    send_byte(words[0][15:8], 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      total++;
      if (load_error !== 1'b0) begin
        bad++;
        $display("FAIL timeout_early: load_error=%b after %0d idle cycles, required 0", load_error, k);
      end
      @(negedge clk);
    end
    check_flags("timeout", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_flags("timeout_hit", 1'b0, 1'b1, 1'b1);
    check_writes("timeout", 0);
  endtask

  task automatic test_reset_midload();
    words[0] = $urandom;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 0);
    total++;
    if (imem_we !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pending: imem_we=%b, required 1", imem_we);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({imem_we, core_hold} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_mask: imem_we=%b core_hold=%b, required 0 0", imem_we, core_hold);
    end
    @(negedge clk);
    total++;
    if ({byte_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_error} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
               byte_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_error);
    end
    reset = 1'b0;
    @(negedge clk);
    clear_writes();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    words[0] = 32'h0000_0013;
    pulse_start();
    send_image(1, 0, 0, 8'h12, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("chk_good", 1);
    check_flags("chk_good", 1'b1, 1'b0, 1'b0);
    pulse_start();
    send_image(1, 0, 0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("chk_bad", 1);
    check_flags("chk_bad", 1'b0, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_random();
    test_zero_len();
    test_oversize();
    test_depth_boundary();
    test_timeout();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
